// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// Holds the FSM state encoding, the performance counter width and the weight clamp.
// Optional packet counters are enabled with the ARB_WRR_PERF_CNT_EN macro.
package arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int PERF_CNT_W = 16;

    // A programmed weight of zero still grants one packet per turn.
    function automatic logic [31:0] weight_eff(input logic [31:0] w);
        return (w == 32'd0) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Rotating-priority first-set picker: scans req from ptr upwards with wrap-around.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
module arb_rr_pick
    import arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] mask;
    logic [2*N-1:0] masked;
    logic [2*N-1:0] first;

    // Duplicate the request vector, clear bits below ptr, isolate the lowest
    // remaining bit and fold both halves back onto N bits.
    always_comb begin
        dbl    = {req, req};
        mask   = ~(((2*N)'(1) << ptr) - (2*N)'(1));
        masked = dbl & mask;
        first  = masked & (~masked + (2*N)'(1));
        onehot = first[N-1:0] | first[2*N-1:N];
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) begin
                idx = IDX_W'(i);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/arb_wrr.sv
// Weighted round-robin arbiter: holds the grant for whole packets, up to weight packets per turn.
// Latency: request to grant 1 cycle; one idle ARB cycle between packets.
// Backpressure: out_rdy low freezes the current grant indefinitely. Optional ARB_WRR_PERF_CNT_EN adds pkt_cnt.
module arb_wrr
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int WEIGHT_W = 4,
    parameter int IDX_W    = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            req_vld,
    input  logic [N-1:0]            req_last,
    input  logic [N*WEIGHT_W-1:0]   weight,
    input  logic                    out_rdy,
    output logic [N-1:0]            grant,
    output logic                    grant_vld,
    output logic [IDX_W-1:0]        grant_idx
`ifdef ARB_WRR_PERF_CNT_EN
    ,
    output logic [N*PERF_CNT_W-1:0] pkt_cnt
`endif
);

    arb_state_e          state, state_nxt;
    logic [IDX_W-1:0]    ptr, ptr_nxt;
    logic [IDX_W-1:0]    holder, holder_nxt;
    logic [WEIGHT_W-1:0] credit, credit_nxt;
    logic [N-1:0]        grant_nxt;

    logic [N-1:0]        pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic [WEIGHT_W-1:0] weight_sel;
    logic [WEIGHT_W-1:0] credit_load;
    logic                pkt_done;

    arb_rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req_vld),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign weight_sel  = weight[pick_idx*WEIGHT_W +: WEIGHT_W];
    assign credit_load = WEIGHT_W'(weight_eff(32'(weight_sel)));
    assign pkt_done    = (state == BUSY) && req_vld[holder] && out_rdy && req_last[holder];
    assign grant_vld   = |grant;
    assign grant_idx   = grant_vld ? holder : '0;

    // Next-state: pick a winner in ARB, hold the grant in BUSY until the last beat.
    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        holder_nxt = holder;
        credit_nxt = credit;
        ptr_nxt    = ptr;
        case (state)
            ARB: begin
                if (pick_any) begin
                    grant_nxt  = pick_onehot;
                    holder_nxt = pick_idx;
                    state_nxt  = BUSY;
                    // A returning holder with credit left keeps its remaining turn.
                    if (credit == '0 || pick_idx != holder) begin
                        credit_nxt = credit_load;
                    end
                end
            end
            BUSY: begin
                if (pkt_done) begin
                    grant_nxt = '0;
                    state_nxt = ARB;
                    if (credit > WEIGHT_W'(1)) begin
                        credit_nxt = credit - WEIGHT_W'(1);
                        ptr_nxt    = holder;
                    end else begin
                        credit_nxt = '0;
                        ptr_nxt    = (holder == IDX_W'(N-1)) ? '0 : holder + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = ARB;
                grant_nxt = '0;
            end
        endcase
    end

    // Arbitration state registers; reset clears the grant immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ARB;
            grant  <= '0;
            holder <= '0;
            credit <= '0;
            ptr    <= '0;
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            holder <= holder_nxt;
            credit <= credit_nxt;
            ptr    <= ptr_nxt;
        end
    end

`ifdef ARB_WRR_PERF_CNT_EN
    // Per-requester completed-packet counters, wrapping at 2^16.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt <= '0;
        end else if (pkt_done) begin
            pkt_cnt[holder*PERF_CNT_W +: PERF_CNT_W] <=
                pkt_cnt[holder*PERF_CNT_W +: PERF_CNT_W] + PERF_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_arb_wrr.sv
// Self-checking bench for arb_wrr: expected grant order is queued at stimulus time
// and compared when each new grant appears.
// Packet counter checks run only when ARB_WRR_PERF_CNT_EN is defined.
module tb_arb_wrr;

    localparam int N  = 4;
    localparam int WW = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_vld;
    logic [N-1:0]    req_last;
    logic [N*WW-1:0] weight;
    logic            out_rdy;
    logic [N-1:0]    grant;
    logic            grant_vld;
    logic [IW-1:0]   grant_idx;
`ifdef ARB_WRR_PERF_CNT_EN
    logic [N*16-1:0] pkt_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int mon_e;
    logic prev_vld = 1'b0;

    arb_wrr #(
        .N        (N),
        .WEIGHT_W (WW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_vld   (req_vld),
        .req_last  (req_last),
        .weight    (weight),
        .out_rdy   (out_rdy),
        .grant     (grant),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx)
`ifdef ARB_WRR_PERF_CNT_EN
        ,
        .pkt_cnt   (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Scoreboard: each new grant (rising grant_vld) must match the next queued index.
    always @(negedge clk) begin
        if (rst) begin
            prev_vld = 1'b0;
        end else begin
            if (grant_vld && !prev_vld) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_grant", 32'(grant_idx), 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("grant_idx", 32'(grant_idx), 32'(mon_e));
                    check("grant_onehot", 32'(grant), 32'(1) << mon_e);
                end
            end
            prev_vld = grant_vld;
        end
    end

    task automatic do_reset();
        rst      = 1'b1;
        req_vld  = '0;
        req_last = '0;
        out_rdy  = 1'b1;
        weight   = 16'h1111;
        repeat (2) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_grant_vld", 32'(grant_vld), 32'd0);
        check("rst_grant_idx", 32'(grant_idx), 32'd0);
        rst = 1'b0;
    endtask

    // Continuous single-beat packets from the requesters in r for n grants.
    task automatic run_pkts(input logic [N-1:0] r, input logic [N*WW-1:0] w, input int n);
        weight   = w;
        req_vld  = r;
        req_last = r;
        out_rdy  = 1'b1;
        for (int k = 0; k < 2*n; k++) @(negedge clk);
        req_vld  = '0;
        req_last = '0;
        repeat (3) @(negedge clk);
        check("sb_drain", 32'(exp_q.size()), 32'd0);
    endtask

    logic [7:0] rdy_tab;

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        do_reset();

        // Idle: no requests means no grant.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_grant", 32'(grant), 32'd0);
            check("idle_vld", 32'(grant_vld), 32'd0);
            check("idle_idx", 32'(grant_idx), 32'd0);
        end

        // Equal weights, all requesting: plain rotation with a bubble per packet.
        do_reset();
        exp_q = '{0, 1, 2, 3, 0};
        weight = 16'h1111; req_vld = 4'b1111; req_last = 4'b1111; out_rdy = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check("bubble_vld", 32'(grant_vld), 32'(k % 2));
        end
        req_vld = '0; req_last = '0;
        repeat (3) @(negedge clk);
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        // Requester 0 has weight 3.
        do_reset();
        exp_q = '{0, 0, 0, 1, 2, 3, 0, 0, 0};
        run_pkts(4'b1111, {4'd1, 4'd1, 4'd1, 4'd3}, 9);

        // Multi-beat packet with stalls; a new request mid-packet must not disturb the grant.
        do_reset();
        exp_q = '{2, 0};
        rdy_tab = 8'b1100_1001;   // bit k-1 drives out_rdy for the edge after negedge k
        req_vld = 4'b0100; req_last = 4'b0000; out_rdy = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("pkt_hold", 32'(grant), 32'h4);
            if (k == 2) req_vld = 4'b0101;
            out_rdy  = rdy_tab[k-1];
            req_last = (k == 8) ? 4'b0100 : 4'b0000;
        end
        @(negedge clk);
        check("pkt_release", 32'(grant), 32'd0);
        req_vld = 4'b0001; req_last = 4'b0001; out_rdy = 1'b1;
        @(negedge clk);
        check("pkt_next_grant", 32'(grant), 32'h1);
        @(negedge clk);
        req_vld = '0; req_last = '0;
        repeat (2) @(negedge clk);
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        // Weight 0 behaves as 1.
        do_reset();
        exp_q = '{0, 1, 0, 1};
        run_pkts(4'b0011, 16'h1110, 4);

        // Pointer wrap: after requester 2, ptr is 3; requesters 3 and 0 alternate.
        do_reset();
        exp_q = '{2, 3, 0, 3};
        weight = 16'h1111; req_vld = 4'b0100; req_last = 4'b0100; out_rdy = 1'b1;
        @(negedge clk);
        req_vld = 4'b1101; req_last = 4'b1101;
        @(negedge clk);
        req_vld = 4'b1001; req_last = 4'b1001;
        repeat (6) @(negedge clk);
        req_vld = '0; req_last = '0;
        repeat (3) @(negedge clk);
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        // Reset mid-packet drops the grant asynchronously.
        do_reset();
        exp_q = '{1};
        req_vld = 4'b0010; req_last = 4'b0000;
        @(negedge clk);
        check("busy_grant", 32'(grant), 32'h2);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_grant", 32'(grant), 32'd0);
        check("async_rst_vld", 32'(grant_vld), 32'd0);
        check("async_rst_idx", 32'(grant_idx), 32'd0);
        req_vld = '0;
        @(negedge clk);
        rst = 1'b0;
        check("sb_drain", 32'(exp_q.size()), 32'd0);

`ifdef ARB_WRR_PERF_CNT_EN
        // Counter wrap: 70000 packets from requester 1.
        do_reset();
        for (int k = 0; k < 70000; k++) exp_q.push_back(1);
        run_pkts(4'b0010, 16'h1111, 70000);
        check("pkt_cnt0", 32'(pkt_cnt[15:0]), 32'd0);
        check("pkt_cnt1", 32'(pkt_cnt[31:16]), 32'd4464);
        check("pkt_cnt2", 32'(pkt_cnt[47:32]), 32'd0);
        check("pkt_cnt3", 32'(pkt_cnt[63:48]), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arb_wrr.md
Name: arb_wrr

Overview:
Parametrised weighted round-robin arbiter with packet locking, the successor to the team's single-cycle round-robin arbiter. It arbitrates N requesters onto one shared valid/ready output. Each requester holds the grant for a whole multi-beat packet, up to a programmable number of consecutive packets (its weight), before priority rotates. It sits in front of shared buses and link ports where back-pressure and multi-beat transfers exist.

Parameters:
N, 4, number of requesters; N >= 2
WEIGHT_W, 4, width of each per-requester weight field
IDX_W, $clog2(N), width of the grant index (derived; do not override)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
req_vld  input  N  per-requester request/beat valid
req_last  input  N  per-requester last-beat marker, qualified by req_vld
weight  input  N*WEIGHT_W  packets allowed per turn; field i is bits [i*WEIGHT_W +: WEIGHT_W]; value 0 treated as 1
out_rdy  input  1  downstream ready
grant  output  N  one-hot grant, registered
grant_vld  output  1  grant is held (equals |grant)
grant_idx  output  IDX_W  binary index of the granted requester; 0 when no grant

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: grant=0, grant_vld=0, grant_idx=0, state=ARB, ptr=0, holder=0, credit=0.
- ptr is the highest-priority index. The winner is the first set bit of req_vld scanning ptr, ptr+1, ... N-1, 0, ... with wrap-around.
- ARB state:
  - If req_vld is 0: stay in ARB; grant stays 0.
  - Otherwise, compute winner w combinationally. On the next edge: grant<=onehot(w), holder<=w, state<=BUSY.
  - Credit on entry: if credit==0 or w!=holder, credit<=max(weight[w],1), sampled at this edge. Otherwise credit is kept.
  - Latency: request to grant is 1 cycle.
- BUSY state:
  - Grant is frozen. A beat occurs when req_vld[holder] && out_rdy.
  - Beat without last: stay in BUSY.
  - Beat with req_last[holder]: the packet is done. On that edge: grant<=0, state<=ARB.
    - If credit>1: credit<=credit-1, ptr<=holder, so the holder re-wins if it is still requesting.
    - If credit==1: credit<=0, ptr<=(holder+1) mod N, with wrap at N-1 to 0.
  - req_vld[holder] low while in BUSY: no beat, grant held. Requesters must not abandon a packet.
  - out_rdy low: grant held indefinitely. No timeout.
- There is exactly one ARB bubble cycle between packets. Maximum output throughput is 1 packet per (beats+1) cycles.
- Simultaneous requests in ARB: the ptr-order winner takes the grant; the others wait. Requests from other requesters arriving during BUSY have no effect until the next ARB cycle.
- If the holder stops requesting while it still has credit, it loses its turn. The next ARB picks another winner, and credit is reloaded for that winner.
- Weight changes take effect only at the next credit reload.
- Reset asserted mid-packet: all state returns to reset values immediately, asynchronously; the grant drops in the same cycle.
- Starvation bound: a continuously requesting requester is granted within sum over other requesters of max(weight,1) packets.

Optional Feature:
Macro ARB_WRR_PERF_CNT_EN.
- Defined: adds output pkt_cnt, N*16 bits. Field i counts packets completed by requester i, i.e. beats with last.
  - Each field wraps at 2^16-1 to 0.
  - Reset value is 0.
  - The field updates on the packet-done edge.
- Undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package arb_pkg:
  - state enum arb_state_e {ARB, BUSY}
  - localparam PERF_CNT_W=16
  - function weight_eff(w), returning w==0 ? 1 : w
- Sub-module arb_rr_pick, purely combinational:
  - inputs: req[N] and ptr[IDX_W]
  - outputs: onehot winner, index, any
  - implemented by the double-width masked first-set method

Test Plan:
- Reset, then req_vld=4'b0000 for 10 cycles -> grant=0, grant_vld=0, grant_idx=0 throughout. Assert rst mid-BUSY -> grant drops the same cycle.
- Weights all 1, req_vld=4'b1111, single-beat packets, out_rdy=1 -> grant_idx sequence 0,1,2,3,0, each grant followed by one bubble cycle.
- weight=={4'd1,4'd1,4'd1,4'd3} (requester 0 has 3), all requesting, single-beat packets -> grant_idx sequence 0,0,0,1,2,3,0,0,0.
- Requester 2 alone sends a 4-beat packet, out_rdy low on beats 2 and 3 for 2 cycles each -> grant stays 4'b0100 for the 8 cycles of the packet. Requester 0 raising req_vld mid-packet causes no grant change.
- weight field 0 = 0, requesters 0 and 1 requesting -> requester 0 gets exactly 1 packet per turn (0 treated as 1). Index wrap: ptr=3, requesters 3 and 0 active with weight 1 -> order 3,0,3.
- With ARB_WRR_PERF_CNT_EN defined, 70000 single-beat packets from requester 1 -> pkt_cnt[1] = 70000 mod 65536 = 4464; the other fields are 0.
